// File: rtl/mem_wb_pkg.sv
// ============================================================================
// mem_wb_pkg : shared encodings and defaults for the MEM/WB pipeline end
// Revision   : 1.0
// ============================================================================
`default_nettype none

package mem_wb_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [2:0] {
      ACUM_NO_LOAD      = 3'b000,
      ACUM_LOAD_CONST_A = 3'b001,
      ACUM_LOAD_MEM_A   = 3'b010,
      ACUM_LOAD_CONST_B = 3'b011,
      ACUM_LOAD_MEM_B   = 3'b100
   } acum_ctrl_e;

   typedef enum logic [1:0] {
      STORE_NONE    = 2'b00,
      STORE_A       = 2'b01,
      STORE_B       = 2'b10,
      STORE_ILLEGAL = 2'b11
   } store_sel_e;

   function automatic logic ctrl_targets_a(input logic [2:0] ctrl);
      return (ctrl == ACUM_LOAD_CONST_A) || (ctrl == ACUM_LOAD_MEM_A);
   endfunction

   function automatic logic ctrl_targets_b(input logic [2:0] ctrl);
      return (ctrl == ACUM_LOAD_CONST_B) || (ctrl == ACUM_LOAD_MEM_B);
   endfunction

   function automatic logic ctrl_is_illegal(input logic [2:0] ctrl);
      return ctrl > ACUM_LOAD_MEM_B;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_data_ram.sv
// ============================================================================
// mem_wb_data_ram : 2^ADDR_W x DATA_W data memory, sync write + sync read
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mem_wb_data_ram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // Contents are deliberately not reset; a same-edge write/read returns old data.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_wb.sv
// ============================================================================
// mem_wb : MEM and WB stages of the accumulator pipeline with data memory
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_wb
   import mem_wb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              iValid,
   input  logic              iFlush,
   input  logic [DATA_W-1:0] iAluData,
   input  logic [DATA_W-1:0] iConst,
   input  logic [ADDR_W-1:0] iAddr,
   input  logic [2:0]        iControlAcum,
   input  logic              iMemRead,
   input  logic [1:0]        iStoreSel,
   output logic [DATA_W-1:0] oAcumA,
   output logic [DATA_W-1:0] oAcumB,
   output logic              oWbValid,
   output logic              oIllegal
);

   logic              mem_valid_q, mem_valid_d;
   logic [DATA_W-1:0] mem_alu_q,   mem_alu_d;
   logic [DATA_W-1:0] mem_const_q, mem_const_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [2:0]        mem_ctrl_q,  mem_ctrl_d;
   logic              mem_read_q,  mem_read_d;
   logic [1:0]        mem_store_q, mem_store_d;

   logic              wb_valid_q,   wb_valid_d;
   logic [DATA_W-1:0] wb_alu_q,     wb_alu_d;
   logic [DATA_W-1:0] wb_const_q,   wb_const_d;
   logic [2:0]        wb_ctrl_q,    wb_ctrl_d;
   logic              wb_read_q,    wb_read_d;
   logic              wb_illegal_q, wb_illegal_d;

   logic [DATA_W-1:0] acum_a_q, acum_a_d;
   logic [DATA_W-1:0] acum_b_q, acum_b_d;

   logic [DATA_W-1:0] ram_rdata;
   logic [DATA_W-1:0] wb_value;
   logic [DATA_W-1:0] acum_a_byp;
   logic [DATA_W-1:0] acum_b_byp;
   logic              store_we;
   logic [DATA_W-1:0] store_data;

   mem_wb_data_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_data_ram (
      .clk   (clk),
      .we    (store_we),
      .waddr (mem_addr_q),
      .wdata (store_data),
      .raddr (mem_addr_q),
      .rdata (ram_rdata)
   );

   always_comb begin
      wb_value = '0;
      case (wb_ctrl_q)
         ACUM_LOAD_CONST_A,
         ACUM_LOAD_CONST_B: wb_value = wb_const_q;
         ACUM_LOAD_MEM_A,
         ACUM_LOAD_MEM_B:   wb_value = wb_read_q ? ram_rdata : wb_alu_q;
         default:           wb_value = '0;
      endcase

      acum_a_byp = (wb_valid_q && ctrl_targets_a(wb_ctrl_q)) ? wb_value : acum_a_q;
      acum_b_byp = (wb_valid_q && ctrl_targets_b(wb_ctrl_q)) ? wb_value : acum_b_q;

      // Stores see the bypassed accumulator so a result one stage ahead is not lost.
      store_we   = !reset && !iFlush && mem_valid_q &&
                   ((mem_store_q == STORE_A) || (mem_store_q == STORE_B));
      store_data = (mem_store_q == STORE_A) ? acum_a_byp : acum_b_byp;
   end

   always_comb begin
      mem_valid_d  = iValid && !iFlush;
      mem_alu_d    = iAluData;
      mem_const_d  = iConst;
      mem_addr_d   = iAddr;
      mem_ctrl_d   = iControlAcum;
      mem_read_d   = iMemRead;
      mem_store_d  = iStoreSel;

      wb_valid_d   = mem_valid_q && !iFlush;
      wb_alu_d     = mem_alu_q;
      wb_const_d   = mem_const_q;
      wb_ctrl_d    = mem_ctrl_q;
      wb_read_d    = mem_read_q;
      wb_illegal_d = ctrl_is_illegal(mem_ctrl_q) || (mem_store_q == STORE_ILLEGAL);

      acum_a_d     = acum_a_byp;
      acum_b_d     = acum_b_byp;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_valid_q <= 1'b0;
         wb_valid_q  <= 1'b0;
         acum_a_q    <= '0;
         acum_b_q    <= '0;
      end else begin
         mem_valid_q <= mem_valid_d;
         wb_valid_q  <= wb_valid_d;
         acum_a_q    <= acum_a_d;
         acum_b_q    <= acum_b_d;
      end
   end

   // Payload registers are qualified by the valid bits and need no reset.
   always_ff @(posedge clk) begin
      mem_alu_q    <= mem_alu_d;
      mem_const_q  <= mem_const_d;
      mem_addr_q   <= mem_addr_d;
      mem_ctrl_q   <= mem_ctrl_d;
      mem_read_q   <= mem_read_d;
      mem_store_q  <= mem_store_d;
      wb_alu_q     <= wb_alu_d;
      wb_const_q   <= wb_const_d;
      wb_ctrl_q    <= wb_ctrl_d;
      wb_read_q    <= wb_read_d;
      wb_illegal_q <= wb_illegal_d;
   end

   assign oAcumA   = acum_a_byp;
   assign oAcumB   = acum_b_byp;
   assign oWbValid = wb_valid_q;
   assign oIllegal = wb_valid_q && wb_illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb.sv
// ============================================================================
// tb_mem_wb : directed vector table plus randomized run against an
//             instruction-level reference model of mem_wb
// Revision  : 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb;

   logic       clk = 1'b0;
   logic       reset, iValid, iFlush, iMemRead;
   logic [7:0] iAluData, iConst;
   logic [9:0] iAddr;
   logic [2:0] iControlAcum;
   logic [1:0] iStoreSel;
   logic [7:0] oAcumA, oAcumB;
   logic       oWbValid, oIllegal;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_wb dut (
      .clk          (clk),
      .reset        (reset),
      .iValid       (iValid),
      .iFlush       (iFlush),
      .iAluData     (iAluData),
      .iConst       (iConst),
      .iAddr        (iAddr),
      .iControlAcum (iControlAcum),
      .iMemRead     (iMemRead),
      .iStoreSel    (iStoreSel),
      .oAcumA       (oAcumA),
      .oAcumB       (oAcumB),
      .oWbValid     (oWbValid),
      .oIllegal     (oIllegal)
   );

   // ---------------- reference model: whole instructions moving through ----
   typedef struct {
      logic       v;
      logic [2:0] ctrl;
      logic       rd;
      logic [1:0] st;
      logic [7:0] cst;
      logic [7:0] alu;
      logic [9:0] addr;
      logic [7:0] ldval;
   } instr_t;

   instr_t     m_mem, m_wb;
   logic [7:0] acc_a, acc_b;
   logic [7:0] ref_mem [1024];
   logic       known   [1024];

   function automatic int target(input logic [2:0] c);
      if (c == 3'd1 || c == 3'd2) return 1;
      if (c == 3'd3 || c == 3'd4) return 2;
      return 0;
   endfunction

   function automatic logic [7:0] result(input instr_t i);
      if (i.ctrl == 3'd1 || i.ctrl == 3'd3) return i.cst;
      if (i.ctrl == 3'd2 || i.ctrl == 3'd4) return i.rd ? i.ldval : i.alu;
      return 8'h00;
   endfunction

   function automatic logic [7:0] visible(input int which);
      if (m_wb.v && target(m_wb.ctrl) == which) return result(m_wb);
      return (which == 1) ? acc_a : acc_b;
   endfunction

   task automatic model_edge();
      logic [7:0] va, vb;
      instr_t     nwb;
      va = visible(1);
      vb = visible(2);
      if (reset) begin
         acc_a = 8'h00; acc_b = 8'h00;
         m_mem.v = 1'b0; m_wb.v = 1'b0;
         return;
      end
      acc_a = va;
      acc_b = vb;
      nwb       = m_mem;
      nwb.ldval = ref_mem[m_mem.addr];
      if (iFlush) nwb.v = 1'b0;
      if (nwb.v && nwb.st == 2'd1) begin ref_mem[nwb.addr] = va; known[nwb.addr] = 1'b1; end
      if (nwb.v && nwb.st == 2'd2) begin ref_mem[nwb.addr] = vb; known[nwb.addr] = 1'b1; end
      m_wb = nwb;
      m_mem.v    = iValid && !iFlush;
      m_mem.ctrl = iControlAcum;
      m_mem.rd   = iMemRead;
      m_mem.st   = iStoreSel;
      m_mem.cst  = iConst;
      m_mem.alu  = iAluData;
      m_mem.addr = iAddr;
   endtask

   // ---------------- helpers --------------------------------------------------
   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %02h expected %02h", nm, $time, act, exp);
      end
   endtask

   task automatic step(input logic rst, input logic v, input logic fl,
                       input logic [2:0] ctrl, input logic rd, input logic [1:0] st,
                       input logic [7:0] cst, input logic [7:0] alu, input logic [9:0] addr);
      reset = rst; iValid = v; iFlush = fl; iControlAcum = ctrl; iMemRead = rd;
      iStoreSel = st; iConst = cst; iAluData = alu; iAddr = addr;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   typedef struct {
      logic       rst, v, fl;
      logic [2:0] ctrl;
      logic       rd;
      logic [1:0] st;
      logic [7:0] cst, alu;
      logic [9:0] addr;
      logic [7:0] ea, eb;
      logic       ewv, eil;
   } vec_t;

   vec_t       vecs [27];
   logic [9:0] pool [8];

   initial begin
      m_mem.v = 1'b0; m_wb.v = 1'b0; acc_a = 8'h00; acc_b = 8'h00;
      for (int i = 0; i < 1024; i++) begin ref_mem[i] = 8'h00; known[i] = 1'b0; end

      //           rst  v    fl   ctrl rd   st   cst    alu    addr     eA     eB     wv   ill
      vecs[ 0] = '{1'b1,1'b0,1'b0,3'd0,1'b0,2'd0,8'h00,8'h00,10'h000,8'h00,8'h00,1'b0,1'b0};
      vecs[ 1] = '{1'b0,1'b1,1'b0,3'd1,1'b0,2'd0,8'h5A,8'h00,10'h000,8'h00,8'h00,1'b0,1'b0};
      vecs[ 2] = '{1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,8'h00,8'h00,10'h000,8'h5A,8'h00,1'b1,1'b0};
      vecs[ 3] = '{1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,8'h00,8'h00,10'h000,8'h5A,8'h00,1'b0,1'b0};
      vecs[ 4] = '{1'b0,1'b1,1'b0,3'd1,1'b0,2'd0,8'h12,8'h00,10'h000,8'h5A,8'h00,1'b0,1'b0};
      vecs[ 5] = '{1'b0,1'b1,1'b0,3'd0,1'b0,2'd1,8'h00,8'h00,10'h3FF,8'h12,8'h00,1'b1,1'b0};
      vecs[ 6] = '{1'b0,1'b1,1'b0,3'd4,1'b1,2'd0,8'h00,8'h00,10'h3FF,8'h12,8'h00,1'b1,1'b0};
      vecs[ 7] = '{1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,8'h00,8'h00,10'h000,8'h12,8'h12,1'b1,1'b0};
      vecs[ 8] = '{1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,8'h00,8'h00,10'h000,8'h12,8'h12,1'b0,1'b0};
      vecs[ 9] = '{1'b0,1'b1,1'b0,3'd2,1'b0,2'd0,8'h00,8'h80,10'h000,8'h12,8'h12,1'b0,1'b0};
      vecs[10] = '{1'b0,1'b1,1'b0,3'd2,1'b0,2'd0,8'h00,8'h81,10'h000,8'h80,8'h12,1'b1,1'b0};
      vecs[11] = '{1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,8'h00,8'h00,10'h000,8'h81,8'h12,1'b1,1'b0};
      vecs[12] = '{1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,8'h00,8'h00,10'h000,8'h81,8'h12,1'b0,1'b0};
      vecs[13] = '{1'b0,1'b1,1'b0,3'd1,1'b0,2'd0,8'h01,8'h00,10'h000,8'h81,8'h12,1'b0,1'b0};
      vecs[14] = '{1'b0,1'b1,1'b0,3'd1,1'b0,2'd0,8'h02,8'h00,10'h000,8'h01,8'h12,1'b1,1'b0};
      vecs[15] = '{1'b0,1'b1,1'b1,3'd1,1'b0,2'd0,8'h03,8'h00,10'h000,8'h01,8'h12,1'b0,1'b0};
      vecs[16] = '{1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,8'h00,8'h00,10'h000,8'h01,8'h12,1'b0,1'b0};
      vecs[17] = '{1'b0,1'b1,1'b0,3'd6,1'b0,2'd0,8'hFF,8'h00,10'h000,8'h01,8'h12,1'b0,1'b0};
      vecs[18] = '{1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,8'h00,8'h00,10'h000,8'h01,8'h12,1'b1,1'b1};
      vecs[19] = '{1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,8'h00,8'h00,10'h000,8'h01,8'h12,1'b0,1'b0};
      vecs[20] = '{1'b0,1'b1,1'b0,3'd0,1'b0,2'd1,8'h00,8'h00,10'h055,8'h01,8'h12,1'b0,1'b0};
      vecs[21] = '{1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,8'h00,8'h00,10'h000,8'h01,8'h12,1'b1,1'b0};
      vecs[22] = '{1'b0,1'b1,1'b0,3'd0,1'b0,2'd2,8'h00,8'h00,10'h055,8'h01,8'h12,1'b0,1'b0};
      vecs[23] = '{1'b1,1'b1,1'b1,3'd1,1'b0,2'd0,8'h77,8'h00,10'h000,8'h00,8'h00,1'b0,1'b0};
      vecs[24] = '{1'b0,1'b1,1'b0,3'd2,1'b1,2'd0,8'h00,8'h00,10'h055,8'h00,8'h00,1'b0,1'b0};
      vecs[25] = '{1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,8'h00,8'h00,10'h000,8'h01,8'h00,1'b1,1'b0};
      vecs[26] = '{1'b0,1'b0,1'b0,3'd0,1'b0,2'd0,8'h00,8'h00,10'h000,8'h01,8'h00,1'b0,1'b0};

      pool[0] = 10'h000; pool[1] = 10'h001; pool[2] = 10'h002; pool[3] = 10'h003;
      pool[4] = 10'h155; pool[5] = 10'h2AA; pool[6] = 10'h3FE; pool[7] = 10'h3FF;

      step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 8'h00, 8'h00, 10'h000);

      for (int k = 0; k < 27; k++) begin
         step(vecs[k].rst, vecs[k].v, vecs[k].fl, vecs[k].ctrl, vecs[k].rd, vecs[k].st,
              vecs[k].cst, vecs[k].alu, vecs[k].addr);
         chk($sformatf("vec%0d oAcumA", k),   oAcumA,          vecs[k].ea);
         chk($sformatf("vec%0d oAcumB", k),   oAcumB,          vecs[k].eb);
         chk($sformatf("vec%0d oWbValid", k), {7'd0, oWbValid}, {7'd0, vecs[k].ewv});
         chk($sformatf("vec%0d oIllegal", k), {7'd0, oIllegal}, {7'd0, vecs[k].eil});
      end

      for (int n = 0; n < 3000; n++) begin
         logic       r_rst, r_v, r_fl, r_rd;
         logic [2:0] r_ctrl;
         logic [1:0] r_st;
         logic [9:0] r_addr;
         int         s;
         logic       e_wv, e_il;
         r_rst  = ($urandom_range(0, 99) == 0);
         r_v    = ($urandom_range(0, 99) < 85);
         r_fl   = ($urandom_range(0, 99) < 6);
         r_ctrl = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         s      = int'($urandom_range(0, 19));
         r_st   = (s < 10) ? 2'd0 : (s < 14) ? 2'd1 : (s < 18) ? 2'd2 : 2'd3;
         r_addr = pool[$urandom_range(0, 7)];
         r_rd   = $urandom_range(0, 1) == 1 && known[r_addr];
         step(r_rst, r_v, r_fl, r_ctrl, r_rd, r_st, 8'($urandom), 8'($urandom), r_addr);
         e_wv = m_wb.v;
         e_il = m_wb.v && (m_wb.ctrl > 3'd4 || m_wb.st == 2'd3);
         chk("rand oAcumA",   oAcumA,           visible(1));
         chk("rand oAcumB",   oAcumB,           visible(2));
         chk("rand oWbValid", {7'd0, oWbValid}, {7'd0, e_wv});
         chk("rand oIllegal", {7'd0, oIllegal}, {7'd0, e_il});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
